// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a start bit, then shifts a byte, its odd parity
// and a released stop bit on device-generated falling clock edges. It then
// checks the device acknowledge and waits for both lines to go idle.
// Lines are open-collector: the *_oe outputs only ever pull low.
// Optional feature macro: PS2_HOST_TX_TIMEOUT_EN enables a watchdog over the
// START/SHIFT/ACK states that aborts the frame with tx_err.
`timescale 1ns/1ps

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 50,
   parameter int TIMEOUT_CYCLES = 7500
) (
   input  logic       CLK_CPU,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_done,
   output logic       tx_err,
   output logic       busy
);

   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_START     = 3'd2,
      S_SHIFT     = 3'd3,
      S_ACK       = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   // Odd parity: the nine bits data+parity always contain an odd count of ones
   function automatic logic odd_parity(input logic [7:0] d);
      return ~(^d);
   endfunction

   state_t           r_state, w_state_nxt;
   logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_nxt;
   logic [3:0]       r_bit_idx, w_bit_idx_nxt;
   logic [9:0]       r_frame, w_frame_nxt;     // {stop, parity, data[7:0]}
   logic             r_clk_oe, w_clk_oe_nxt;
   logic             r_data_oe, w_data_oe_nxt;
   logic             r_done, w_done_nxt;
   logic             r_err, w_err_nxt;
   logic             r_ready;
   logic             r_busy;

   logic             r_clk_meta, r_clk_sync, r_clk_prev;
   logic             r_data_meta, r_data_sync;
   logic             w_clk_fall;
   logic             w_timeout;

   assign w_clk_fall = r_clk_prev & ~r_clk_sync;

   // Two-flop line synchronisers plus a delayed clock sample for edge detection
   always_ff @(posedge CLK_CPU or negedge resetn) begin
      if (!resetn) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_clk_prev  <= 1'b1;
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
      end else begin
         r_clk_meta  <= ps2_clk_in;
         r_clk_sync  <= r_clk_meta;
         r_clk_prev  <= r_clk_sync;
         r_data_meta <= ps2_data_in;
         r_data_sync <= r_data_meta;
      end
   end

`ifdef PS2_HOST_TX_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_in_wait;

   assign w_in_wait = (r_state == S_START) || (r_state == S_SHIFT) || (r_state == S_ACK);
   assign w_timeout = w_in_wait && (r_tmo_cnt == TMO_LAST);

   // Watchdog: zero outside the edge-waiting states, so it restarts at START entry
   always_ff @(posedge CLK_CPU or negedge resetn) begin
      if (!resetn) begin
         r_tmo_cnt <= {TMO_W{1'b0}};
      end else if (w_in_wait) begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
         r_tmo_cnt <= {TMO_W{1'b0}};
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state and next-output decode; outputs are registered from these values
   always_comb begin
      w_state_nxt   = r_state;
      w_inh_cnt_nxt = r_inh_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_frame_nxt   = r_frame;
      w_clk_oe_nxt  = r_clk_oe;
      w_data_oe_nxt = r_data_oe;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            if (tx_valid && r_ready) begin
               w_frame_nxt   = {1'b1, odd_parity(tx_data), tx_data};
               w_inh_cnt_nxt = {INH_W{1'b0}};
               w_bit_idx_nxt = 4'd0;
               w_state_nxt   = S_INHIBIT;
               w_clk_oe_nxt  = 1'b1;
               w_data_oe_nxt = (INH_LAST == {INH_W{1'b0}});
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_INHIBIT: begin
            w_clk_oe_nxt = 1'b1;
            if (r_inh_cnt == INH_LAST) begin
               // Release the clock with data already low: that is the start bit
               w_state_nxt   = S_START;
               w_inh_cnt_nxt = {INH_W{1'b0}};
               w_clk_oe_nxt  = 1'b0;
               w_data_oe_nxt = 1'b1;
            end else begin
               w_inh_cnt_nxt = r_inh_cnt + INH_W'(1);
               w_data_oe_nxt = ((r_inh_cnt + INH_W'(1)) == INH_LAST);
            end
         end
         S_START: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b1;
            if (w_timeout) begin
               w_state_nxt   = S_IDLE;
               w_data_oe_nxt = 1'b0;
               w_err_nxt     = 1'b1;
            end else if (w_clk_fall) begin
               // The entering edge already drives data bit 0
               w_state_nxt   = S_SHIFT;
               w_data_oe_nxt = ~r_frame[0];
               w_bit_idx_nxt = 4'd1;
            end else begin
               w_state_nxt = S_START;
            end
         end
         S_SHIFT: begin
            w_clk_oe_nxt = 1'b0;
            if (w_timeout) begin
               w_state_nxt   = S_IDLE;
               w_data_oe_nxt = 1'b0;
               w_err_nxt     = 1'b1;
            end else if (w_clk_fall) begin
               w_data_oe_nxt = ~r_frame[r_bit_idx];
               if (r_bit_idx == 4'd9) begin
                  w_state_nxt   = S_ACK;
                  w_bit_idx_nxt = 4'd0;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 4'd1;
               end
            end else begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_ACK: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            if (w_timeout) begin
               w_state_nxt = S_IDLE;
               w_err_nxt   = 1'b1;
            end else if (w_clk_fall) begin
               if (!r_data_sync) begin
                  w_state_nxt = S_WAIT_IDLE;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_err_nxt   = 1'b1;
               end
            end else begin
               w_state_nxt = S_ACK;
            end
         end
         S_WAIT_IDLE: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            if (r_clk_sync && r_data_sync) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_WAIT_IDLE;
            end
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge CLK_CPU or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_inh_cnt <= {INH_W{1'b0}};
         r_bit_idx <= 4'd0;
         r_frame   <= 10'd0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_inh_cnt <= w_inh_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_frame   <= w_frame_nxt;
         r_clk_oe  <= w_clk_oe_nxt;
         r_data_oe <= w_data_oe_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_ready   <= (w_state_nxt == S_IDLE);
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign tx_ready    = r_ready;
   assign busy        = r_busy;
   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign tx_done     = r_done;
   assign tx_err      = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a behavioural
// PS/2 device (open-collector lines, 40-cycle device clock period).
`timescale 1ns/1ps

module tb_ps2_host_tx;

   localparam int INH  = 50;
   localparam int TMO  = 7500;
   localparam int HALF = 20;

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         exp_par;
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   logic       CLK_CPU;
   logic       resetn;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       tx_done;
   logic       tx_err;
   logic       busy;
   logic       dev_clk;
   logic       dev_data;
   logic       stop_scr;
   logic       w_clk_line;
   logic       w_data_line;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int n_err   = 0;
   int n_clkoe = 0;
   int n_inh_data = 0;
   int n_both  = 0;
   int n_inv   = 0;
   logic rst_seen;

   assign w_clk_line  = dev_clk & ~ps2_clk_oe;
   assign w_data_line = dev_data & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK_CPU    (CLK_CPU),
      .resetn     (resetn),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ps2_clk_in (w_clk_line),
      .ps2_data_in(w_data_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .busy       (busy)
   );

   initial CLK_CPU = 1'b0;
   always #5 CLK_CPU = ~CLK_CPU;

   // Tracks whether at least one clock edge has passed with reset released
   always @(posedge CLK_CPU) rst_seen <= resetn;

   // Output monitor sampled away from the active edge
   always @(negedge CLK_CPU) begin
      if (tx_done) n_done <= n_done + 1;
      if (tx_err) n_err <= n_err + 1;
      if (ps2_clk_oe) n_clkoe <= n_clkoe + 1;
      if (ps2_clk_oe && ps2_data_oe) n_inh_data <= n_inh_data + 1;
      if (tx_done && tx_err) n_both <= n_both + 1;
      if (resetn && rst_seen && (tx_ready === busy)) n_inv <= n_inv + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference frame as seen by the device: {stop, odd parity, data LSB first, start}
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      int ones;
      logic par;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += (int'(b) >> i) & 1;
      par = ((ones % 2) == 0);
      return {1'b1, par, b, 1'b0};
   endfunction

   // Behavioural device: waits for the request-to-send, clocks 11 edges, optionally acks
   task automatic dev_frame(input bit ack, input int nclk, output logic [10:0] bits, output bit ok);
      int t;
      bits = 11'h7FF;
      ok = 1'b0;
      t = 0;
      while (w_clk_line !== 1'b0 && t < 400) begin @(negedge CLK_CPU); t++; end
      if (t >= 400) begin stop_scr = 1'b1; return; end
      t = 0;
      while (!(w_clk_line === 1'b1 && w_data_line === 1'b0) && t < 400) begin
         @(negedge CLK_CPU); t++;
      end
      if (t >= 400) begin stop_scr = 1'b1; return; end
      ok = 1'b1;
      repeat (10) @(negedge CLK_CPU);
      bits[0] = w_data_line;
      for (int i = 1; i <= nclk; i++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge CLK_CPU);
         if (i <= 10) bits[i] = w_data_line;
         dev_clk = 1'b1;
         if (i == 10) begin
            repeat (HALF / 2) @(negedge CLK_CPU);
            stop_scr = 1'b1;
            if (ack) dev_data = 1'b0;
            repeat (HALF / 2) @(negedge CLK_CPU);
         end else if (i == 11) begin
            repeat (5) @(negedge CLK_CPU);
            dev_data = 1'b1;
         end else begin
            repeat (HALF) @(negedge CLK_CPU);
         end
      end
   endtask

   task automatic issue(input logic [7:0] b, input bit keep);
      int t;
      t = 0;
      while (tx_ready !== 1'b1 && t < 100) begin @(negedge CLK_CPU); t++; end
      check("issue_ready_wait", (t < 100), 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge CLK_CPU);
      if (!keep) tx_valid = 1'b0;
   endtask

   task automatic do_xfer(input string tag, input logic [7:0] b, input bit ack,
                          input logic [10:0] exp_bits, input bit exp_done, input bit exp_err,
                          input bit hold, input logic [7:0] next_b, input bit started);
      int d0, e0, c0, i0, t;
      logic [10:0] bits;
      bit ok;
      d0 = n_done; e0 = n_err; c0 = n_clkoe; i0 = n_inh_data;
      stop_scr = 1'b0;
      if (started) begin
         @(negedge CLK_CPU);
         tx_valid = 1'b0;
      end else begin
         issue(b, hold);
      end
      fork
         dev_frame(ack, 11, bits, ok);
         begin : scr
            int k;
            k = 0;
            if (hold) begin
               while (!stop_scr && k < 2000) begin
                  @(negedge CLK_CPU);
                  k++;
                  if ((k % 37) == 0) tx_data = 8'($urandom);
               end
               tx_data = next_b;
            end
         end
      join
      t = 0;
      while (busy !== 1'b0 && t < 200) begin @(negedge CLK_CPU); t++; end
      #1;
      check({tag, "_dev_sync"}, ok, 1);
      check({tag, "_bits"}, bits, exp_bits);
      check({tag, "_idle_wait"}, (t < 200), 1);
      check({tag, "_done"}, n_done - d0, exp_done);
      check({tag, "_err"}, n_err - e0, exp_err);
      check({tag, "_inhibit_len"}, n_clkoe - c0, INH);
      check({tag, "_inhibit_data"}, n_inh_data - i0, 1);
   endtask

   initial begin
      vec_t        vecs[6];
      logic [10:0] bits, expf;
      logic [7:0]  rb;
      bit          rack, ok;
      int          d0, e0, t, k;

      vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'h96, 1'b0, 1'b1, 1'b0, 1'b1};

      resetn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      dev_clk = 1'b1; dev_data = 1'b1; stop_scr = 1'b0;
      repeat (3) @(negedge CLK_CPU);
      check("reset_outputs", {ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err, busy}, 6'b0);
      #1 resetn = 1'b1;
      @(negedge CLK_CPU);
      check("ready_after_reset", {tx_ready, busy}, 2'b10);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         do_xfer($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack,
                 {1'b1, vecs[i].exp_par, vecs[i].data, 1'b0},
                 vecs[i].exp_done, vecs[i].exp_err, 1'b0, 8'h00, 1'b0);
      end

      // Random bytes and ack behaviour against the reference model
      for (int i = 0; i < 6; i++) begin
         rb   = 8'($urandom);
         rack = ($urandom_range(0, 3) != 0);
         do_xfer($sformatf("rnd%0d", i), rb, rack, model_frame(rb), rack, !rack, 1'b0, 8'h00, 1'b0);
      end

      // tx_valid held through the frame with tx_data scrambled; next byte follows
      do_xfer("hold_first", 8'h5A, 1'b1, model_frame(8'h5A), 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0);
      do_xfer("hold_second", 8'hC3, 1'b1, model_frame(8'hC3), 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Reset in the middle of a frame
      d0 = n_done; e0 = n_err;
      issue(8'hAA, 1'b0);
      dev_frame(1'b1, 4, bits, ok);
      expf = model_frame(8'hAA);
      check("abort_dev_sync", ok, 1);
      check("abort_first_bits", bits[4:0], expf[4:0]);
      dev_clk = 1'b0;
      repeat (10) @(negedge CLK_CPU);
      check("abort_pre_drive", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      resetn = 1'b0;
      #1;
      check("abort_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      dev_clk = 1'b1;
      repeat (3) @(negedge CLK_CPU);
      check("abort_reset_outs", {tx_ready, busy, tx_done, tx_err}, 4'b0);
      #1 resetn = 1'b1;
      @(negedge CLK_CPU);
      check("abort_ready_after", {tx_ready, busy}, 2'b10);
      #1;
      check("abort_no_pulse", (n_done - d0) + (n_err - e0), 0);
      do_xfer("after_abort", 8'h55, 1'b1, model_frame(8'h55), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

      // Device never clocks
      e0 = n_err;
      issue(8'h3C, 1'b0);
      t = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 200) begin
         @(negedge CLK_CPU); t++;
      end
      check("reach_start", (t < 200), 1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
      k = 0;
      while (tx_err !== 1'b1 && k < 8000) begin @(negedge CLK_CPU); k++; end
      check("timeout_cycles", k, TMO);
      check("timeout_release", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
`else
      k = 0;
      repeat (8000) @(negedge CLK_CPU);
      check("stuck_in_start", {busy, ps2_clk_oe, ps2_data_oe}, 3'b101);
      #1;
      check("stuck_no_err", n_err - e0, k);
      resetn = 1'b0;
      repeat (2) @(negedge CLK_CPU);
      #1 resetn = 1'b1;
      @(negedge CLK_CPU);
`endif

      #1;
      check("done_err_overlap", n_both, 0);
      check("ready_busy_consistency", n_inv, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 50: CLK_CPU cycles PS/2 clock is held low before start (100 us at 500 kHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 7500: CLK_CPU cycles allowed from clock release to ack edge (15 ms at 500 kHz).
REQ-003 CLK_CPU  in  1  sole clock; all state on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 tx_data  in  8  command byte to the keyboard.
REQ-006 tx_valid  in  1  request; byte accepted on a cycle where tx_valid & tx_ready.
REQ-007 tx_ready  out  1  high only in IDLE.
REQ-008 ps2_clk_in  in  1  raw PS/2 clock line level.
REQ-009 ps2_data_in  in  1  raw PS/2 data line level.
REQ-010 ps2_clk_oe  out  1  1 = drive clock line low; 0 = release (pull-up).
REQ-011 ps2_data_oe  out  1  1 = drive data line low; 0 = release.
REQ-012 tx_done  out  1  one-cycle pulse: byte sent and device acked.
REQ-013 tx_err  out  1  one-cycle pulse: missing ack or timeout.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 ps2_clk_in and ps2_data_in pass through 2-FF synchronisers; clock falling edge = synced previous 1, current 0; edges seen 3 cycles after the line moves.
REQ-016 States: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-017 IDLE: oe both 0; on accept latch tx_data, compute odd parity (parity = ~^tx_data), go INHIBIT.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe asserted in last cycle; then START.
REQ-019 START: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); timeout counter cleared; first falling edge -> SHIFT with bit index 0.
REQ-020 SHIFT: on the same falling edge that entered it and each one after, drive frame bit k (k=0..7 data LSB first, 8 parity, 9 stop); ps2_data_oe = ~bit; bit 9 releases data; after the 10th driven edge go ACK.
REQ-021 ACK: on next falling edge sample synced data: 0 -> WAIT_IDLE; 1 -> tx_err pulse, IDLE.
REQ-022 WAIT_IDLE: when synced clock and data both 1 -> tx_done pulse, IDLE.
REQ-023 tx_done and tx_err never both asserted; at most one pulse per accepted byte.
REQ-024 tx_valid ignored while busy; tx_data only sampled at accept.
REQ-025 Any state: when ps2_data_oe=0 the data line is released; module never drives a line high.

Reset
REQ-026 resetn low immediately (asynchronously) forces IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=0 during reset, tx_done=0, tx_err=0, busy=0, counters 0, synchroniser FFs 1.
REQ-027 Reset mid-frame releases both lines at once; no done/err pulse is produced for the aborted byte; tx_ready=1 in the first cycle after resetn deasserts.

Configuration
REQ-028 Macro PS2_HOST_TX_TIMEOUT_EN defined: timeout counter counts from START entry; reaching TIMEOUT_CYCLES in START/SHIFT/ACK releases both lines, pulses tx_err, returns IDLE.
REQ-029 Macro undefined: no timeout counter; tx_err only from missing ack; START/SHIFT/ACK wait indefinitely for edges.

Verification
REQ-030 Send 0xED, device model clocks 12.5 kHz and acks -> data line bits 0,1,0,1,1,0,1,1,1,1(parity),released stop; tx_done once; clock held low 50 cycles first.
REQ-031 Send 0x01 -> parity bit 0 on edge 9; ack -> tx_done; tx_ready back to 1 after lines idle.
REQ-032 Send 0xFF, device does not pull data at ack edge -> tx_err one cycle, tx_done 0, IDLE.
REQ-033 With PS2_HOST_TX_TIMEOUT_EN, device never clocks -> tx_err exactly 7500 cycles after START entry, both oe 0; without macro -> module stays in START, busy=1.
REQ-034 Assert resetn low after 4th bit of 0xAA -> both oe 0 same cycle, no pulses; after release a new 0x55 transfer completes with tx_done.
REQ-035 tx_valid held high through a transfer with tx_data changed mid-frame -> transmitted byte unchanged; second byte accepted only once tx_ready=1.
